dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder serving the MEM stage of the pipelined MIPS core. It receives load and store requests presented by the EX/MEM register and performs word accesses to an internal memory array after a fixed number of wait states. While an access is in flight, it stalls the pipeline. Read data is registered and held stable so that the MEM/WB register and the WB stage can consume it in the cycle after the access retires.

## Interface
- ADDR_WIDTH, 8, word-index bits; array depth = 2^ADDR_WIDTH words of 32 bits
- WAIT_CYCLES, 2, wait states per access; legal range 0..15

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- MemRead  input  1  load request from EX/MEM
- MemWrite  input  1  store request from EX/MEM
- DataMemoryAddress  input  32  byte address from ALU result
- DataMemoryWriteData  input  32  store data (rt value)
- DataMemoryReadData  output  32  registered load data; holds its value until the next load retires
- MemStall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM while high
- MemAddrError  output  1  misaligned-access flag, combinational; present only with DMEM_ERR_EN

## Operation
- Word index = DataMemoryAddress[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo the array depth.
- Request: req = MemRead | MemWrite, qualified by alignment when DMEM_ERR_EN is defined.
- If MemRead and MemWrite are both high, the access is a store. DataMemoryReadData is not updated.
- Op, word index and write data are latched on acceptance. Later input changes do not affect the access in flight.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on req, load counter = WAIT_CYCLES. Go to WAIT if WAIT_CYCLES > 0, else go to RESP. Without req, stay in IDLE.
  - WAIT: decrement the counter. When the counter reaches 1, the access is performed on that edge and the FSM goes to RESP.
  - RESP: go to IDLE unconditionally. Requests are never accepted in RESP, because EX/MEM still holds the same instruction during this cycle.
- Access commit, on the edge entering RESP:
  - A store writes mem[idx] = latched data.
  - A load loads DataMemoryReadData with mem[idx].
- MemStall = (IDLE & req) | WAIT. MemStall is 0 in RESP, so the pipeline advances at the end of RESP.
- Reset (rst = 0): the FSM goes to IDLE, and the counter, DataMemoryReadData and MemStall go to 0. A pending store is dropped. Array contents are not reset.
- Reset mid-access: abort immediately, with no partial write.

## Timing
- Let request cycle = c, i.e. the first IDLE cycle in which req is seen.
- MemStall is high in cycles c .. c+WAIT_CYCLES and low in cycle c+WAIT_CYCLES+1 (RESP).
- Load data is visible from cycle c+WAIT_CYCLES+1. It remains stable at least through c+WAIT_CYCLES+2, the WB cycle of that load.
- A store is visible to a subsequent load at the next acceptance.
- Back-to-back accesses: the second request is accepted in the IDLE cycle that follows RESP.
  - Minimum access period = WAIT_CYCLES + 2 cycles.
  - With WAIT_CYCLES = 0: 1 stall cycle per access, period 2.
- Load-after-store to the same word returns the new data. There is no bypass needed, because the accesses are serialized.

## Configuration
- DMEM_ERR_EN defined:
  - In IDLE, if req and DataMemoryAddress[1:0] != 0, MemAddrError = 1 for that cycle.
  - The access is discarded: no stall, no state change, memory and read data untouched.
- DMEM_ERR_EN undefined:
  - Address bits [1:0] are ignored and every request is performed.
  - MemAddrError is tied to 0.

## Test plan
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x10, then load 0x10.
  - Required: MemStall high for 3 cycles per access.
  - Required: DataMemoryReadData = 0xDEADBEEF in the RESP cycle of the load, held for the following cycle.
- WAIT_CYCLES=0: alternate loads of 0x0, 0x4 and 0x8, preloaded with 1, 2 and 3.
  - Required: 1 stall cycle per access.
  - Required: read data sequence 1, 2, 3, each held for 2 cycles.
- MemRead=MemWrite=1 at 0x20 with data 0x55: this is a store.
  - Required: DataMemoryReadData keeps its prior value.
  - Required: a later load of 0x20 returns 0x55.
- Address wrap, ADDR_WIDTH=8: store 0xA5 to 0x400, then load 0x0.
  - Required: the load returns 0xA5.
- Assert rst=0 during the second WAIT cycle of a store of 0x77 to 0x30.
  - Required: MemStall drops to 0 and DataMemoryReadData reads 0 immediately.
  - Required: a post-reset load of 0x30 returns the old contents.
- DMEM_ERR_EN defined: load 0x12.
  - Required: MemAddrError = 1 for that cycle and MemStall = 0.
  - Required: the FSM stays in IDLE and read data is unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MIPS MEM stage: word accesses after WAIT_CYCLES wait states.
// Optional misaligned-access detection is enabled by defining DMEM_ERR_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] DataMemoryAddress,
    input  logic [31:0] DataMemoryWriteData,
    output logic [31:0] DataMemoryReadData,
    output logic        MemStall,
    output logic        MemAddrError
);

    // state | meaning
    // IDLE  | waiting for a load/store request from EX/MEM
    // WAIT  | wait states counting down; access commits on the edge leaving WAIT
    // RESP  | access retired, stall released, no new request accepted
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  op_store;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [31:0]           lat_data;
    logic [31:0]           mem [DEPTH];

    logic                  req_raw;
    logic                  req;
    logic [ADDR_WIDTH-1:0] in_idx;
    logic                  commit;
    logic                  c_store;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic [31:0]           c_data;
    logic                  unused_addr_bits;

    assign req_raw          = MemRead | MemWrite;
    assign in_idx           = DataMemoryAddress[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{DataMemoryAddress[31:ADDR_WIDTH+2], DataMemoryAddress[1:0]};

`ifdef DMEM_ERR_EN
    logic addr_err;
    assign addr_err     = (state == IDLE) && req_raw && (DataMemoryAddress[1:0] != 2'b00);
    assign req          = req_raw & ~addr_err;
    assign MemAddrError = addr_err;
`else
    assign req          = req_raw;
    assign MemAddrError = 1'b0;
`endif

    // With zero wait states the access commits straight from IDLE using the live inputs.
    always_comb begin
        commit  = 1'b0;
        c_store = op_store;
        c_idx   = lat_idx;
        c_data  = lat_data;
        if (state == IDLE && req && WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            c_store = MemWrite;
            c_idx   = in_idx;
            c_data  = DataMemoryWriteData;
        end else if (state == WAIT && cnt == 4'd1) begin
            commit = 1'b1;
        end
    end

    assign MemStall = rst & (((state == IDLE) && req) || (state == WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            cnt                <= 4'd0;
            op_store           <= 1'b0;
            lat_idx            <= '0;
            lat_data           <= 32'd0;
            DataMemoryReadData <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cnt      <= WAIT_INIT;
                        op_store <= MemWrite;
                        lat_idx  <= in_idx;
                        lat_data <= DataMemoryWriteData;
                        state    <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit && !c_store) DataMemoryReadData <= mem[c_idx];
        end
    end

    // Array is not reset; the write is gated by rst so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (commit && c_store && rst) mem[c_idx] <= c_data;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: randomized loads/stores against a word-array model.
// Honours DMEM_ERR_EN the same way the design does.
module tb_dmem_responder;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [31:0] DataMemoryAddress, DataMemoryWriteData;
    logic [31:0] DataMemoryReadData;
    logic        MemStall, MemAddrError;

    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .DataMemoryAddress(DataMemoryAddress),
        .DataMemoryWriteData(DataMemoryWriteData),
        .DataMemoryReadData(DataMemoryReadData),
        .MemStall(MemStall), .MemAddrError(MemAddrError)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [31:0] model_mem [256];
    bit          written   [256];
    logic [31:0] last_rd;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Called at a falling edge; returns at the falling edge after the response cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data);
        int          n;
        logic [7:0]  idx;
        logic [31:0] e;
        idx = addr[9:2];
`ifdef DMEM_ERR_EN
        if (addr[1:0] != 2'b00) begin
            MemRead = rd; MemWrite = wr; DataMemoryAddress = addr; DataMemoryWriteData = data;
            #1;
            check("addr_err_flag", 32'(MemAddrError), 32'd1);
            check("addr_err_nostall", 32'(MemStall), 32'd0);
            check("addr_err_rdata", DataMemoryReadData, last_rd);
            @(negedge clk);
            MemRead = 1'b0; MemWrite = 1'b0;
            #1;
            check("addr_err_idle", 32'(MemStall), 32'd0);
            return;
        end
`endif
        if (wr) begin
            model_mem[idx] = data;
            written[idx]   = 1'b1;
            e = last_rd;
        end else begin
            e = model_mem[idx];
        end
        last_rd = e;
        exp_q.push_back(e);
        MemRead = rd; MemWrite = wr; DataMemoryAddress = addr; DataMemoryWriteData = data;
        #1;
        check("err_flag_low", 32'(MemAddrError), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (MemStall && n < 40);
        if (MemStall) check("stall_timeout", 32'd1, 32'd0);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    // Monitor: measures each stall run and checks read data in the response cycle and the one after.
    int          stall_run = 0;
    bit          hold_pending = 0;
    logic [31:0] hold_val;
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                stall_run    = 0;
                hold_pending = 0;
            end else begin
                if (hold_pending) begin
                    check("rdata_hold", DataMemoryReadData, hold_val);
                    hold_pending = 0;
                end
                if (MemStall) stall_run++;
                else if (stall_run > 0) begin
                    if (exp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        check("stall_len", 32'(stall_run), 32'(W + 1));
                        check("resp_rdata", DataMemoryReadData, e);
                        hold_pending = 1;
                        hold_val     = e;
                    end
                    stall_run = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr, data;
        int          kind;
        logic [7:0]  idx;
        logic        rd, wr;

        rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        DataMemoryAddress = 32'd0; DataMemoryWriteData = 32'd0;
        last_rd = 32'd0;
        for (int i = 0; i < 256; i++) written[i] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall", 32'(MemStall), 32'd0);
        check("reset_rdata", DataMemoryReadData, 32'd0);
        check("reset_err", 32'(MemAddrError), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_access(1'b0, 1'b1, 32'h0000_0030, 32'h1122_3344);
        do_access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        do_access(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055);
        do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        do_access(1'b0, 1'b1, 32'h0000_0400, 32'h0000_00A5);
        do_access(1'b1, 1'b0, 32'h0000_0000, 32'h0);
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
`ifdef DMEM_ERR_EN
        do_access(1'b1, 1'b0, 32'h0000_0012, 32'h0);
`endif

        // Reset during the second wait cycle of a store: nothing may land.
        MemWrite = 1'b1; DataMemoryAddress = 32'h30; DataMemoryWriteData = 32'h77;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; MemWrite = 1'b0;
        #1;
        check("midrst_stall", 32'(MemStall), 32'd0);
        check("midrst_rdata", DataMemoryReadData, 32'd0);
        last_rd = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_access(1'b1, 1'b0, 32'h0000_0030, 32'h0);

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            kind = $urandom_range(0, 2);
            addr = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2);
`ifdef DMEM_ERR_EN
            if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
`else
            addr[1:0] = 2'($urandom_range(0, 3));
`endif
            idx = addr[9:2];
            if (kind == 0 && !written[idx]) kind = 1;
            rd   = (kind != 1);
            wr   = (kind != 0);
            data = $urandom;
            do_access(rd, wr, addr, data);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
